// File: rtl/cheat_pgm_loader_pkg.sv
// Shared constants and types for the cheat-engine programming-port writer.
package cheat_pgm_loader_pkg;

  localparam logic [7:0] OP_LOAD_SLOT = 8'h01;
  localparam logic [7:0] OP_SET_MASK  = 8'h02;
  localparam logic [7:0] OP_SET_FLAGS = 8'h03;
  localparam logic [7:0] OP_CLEAR_ALL = 8'h04;
  localparam logic [7:0] OP_CLR_ERR   = 8'h05;

  localparam logic [7:0] NUM_SLOTS     = 8'd6;
  localparam logic [2:0] PGM_IDX_MASK  = 3'd6;
  localparam logic [2:0] PGM_IDX_FLAGS = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_ARG, S_ISSUE, S_ISSUE2} state_t;

  // Number of bytes following the opcode; zero for no-payload and unknown opcodes.
  function automatic logic [2:0] pay_len(input logic [7:0] op);
    case (op)
      OP_LOAD_SLOT: pay_len = 3'd5;
      OP_SET_MASK:  pay_len = 3'd1;
      OP_SET_FLAGS: pay_len = 3'd2;
      default:      pay_len = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/cheat_pgm_rx.sv
// Frame receive datapath: payload byte counter, payload shift register, inter-byte timeout.
module cheat_pgm_rx
  import cheat_pgm_loader_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 96000,
  parameter int TO_W           = 17
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        shift,
  input  logic        counting,
  input  logic [7:0]  data,
  output logic [2:0]  cnt,
  output logic [23:0] payload,
  output logic        timeout
);

  logic [TO_W-1:0] to_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      payload <= '0;
      to_cnt  <= '0;
    end else begin
      if (start)      cnt <= '0;
      else if (shift) cnt <= cnt + 3'd1;
      if (shift) payload <= {payload[15:0], data};
      // Saturates at the limit so the abort condition stays visible until the FSM leaves ARG.
      if (start || shift)              to_cnt <= '0;
      else if (counting && !timeout)   to_cnt <= to_cnt + TO_W'(1);
    end
  end

  assign timeout = (to_cnt == TO_W'(TIMEOUT_CYCLES));

endmodule

// File: rtl/cheat_pgm_loader.sv
// Turns framed MCU command bytes into cheat-engine pgm writes, re-issuing each write until it
// lands in a cycle where the engine is not blocked.
module cheat_pgm_loader
  import cheat_pgm_loader_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 96000,
  parameter int TO_W           = 17
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  input  logic        cmd_sof,
  input  logic [7:0]  cmd_data,
  output logic        cmd_ready,
  input  logic        pgm_block,
  output logic [2:0]  pgm_idx,
  output logic        pgm_we,
  output logic [31:0] pgm_in,
  output logic [5:0]  mask_shadow,
  output logic        busy,
  output logic        err_frame,
  output logic        err_timeout,
  output logic        err_cmd
);

  state_t      state, state_nxt;
  logic [7:0]  op, op_nxt;
  logic [2:0]  idx_nxt;
  logic [31:0] in_nxt;
  logic        bad_slot, bad_nxt;
  logic        set_frame, set_cmd, set_to, clr_err;
  logic        accept, in_arg;
  logic [2:0]  cnt;
  logic [23:0] payload;
  logic        timeout;

  assign cmd_ready = (state == S_IDLE) || (state == S_ARG);
  assign accept    = cmd_valid && cmd_ready;
  assign in_arg    = (state == S_ARG);
  assign busy      = (state != S_IDLE);
  assign pgm_we    = ((state == S_ISSUE) || (state == S_ISSUE2)) && !pgm_block;

  cheat_pgm_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .TO_W(TO_W)) u_rx (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (accept && cmd_sof),
    .shift    (accept && !cmd_sof && in_arg),
    .counting (in_arg),
    .data     (cmd_data),
    .cnt      (cnt),
    .payload  (payload),
    .timeout  (timeout)
  );

  always_comb begin
    state_nxt = state;
    op_nxt    = op;
    idx_nxt   = pgm_idx;
    in_nxt    = pgm_in;
    bad_nxt   = bad_slot;
    set_frame = 1'b0;
    set_cmd   = 1'b0;
    set_to    = 1'b0;
    clr_err   = 1'b0;
    case (state)
      S_IDLE, S_ARG: begin
        if (accept && cmd_sof) begin
          // An SOF always starts a fresh frame; one arriving mid-frame also flags the abort.
          set_frame = in_arg;
          op_nxt    = cmd_data;
          bad_nxt   = 1'b0;
          state_nxt = S_IDLE;
          case (cmd_data)
            OP_LOAD_SLOT, OP_SET_MASK, OP_SET_FLAGS: state_nxt = S_ARG;
            OP_CLEAR_ALL: begin
              state_nxt = S_ISSUE;
              idx_nxt   = PGM_IDX_MASK;
              in_nxt    = '0;
            end
            OP_CLR_ERR: clr_err = 1'b1;
            default:    set_cmd = 1'b1;
          endcase
        end else if (accept && !in_arg) begin
          set_frame = 1'b1;
        end else if (accept) begin
          if (op == OP_LOAD_SLOT && cnt == 3'd0) begin
            if (cmd_data >= NUM_SLOTS) begin
              set_cmd = 1'b1;
              bad_nxt = 1'b1;
            end else begin
              idx_nxt = cmd_data[2:0];
            end
          end
          if (cnt == pay_len(op) - 3'd1) begin
            state_nxt = S_ISSUE;
            case (op)
              OP_LOAD_SLOT: begin
                in_nxt = {payload, cmd_data};
                if (bad_slot) state_nxt = S_IDLE;
              end
              OP_SET_MASK: begin
                idx_nxt = PGM_IDX_MASK;
                in_nxt  = {26'd0, cmd_data[5:0]};
              end
              default: begin
                idx_nxt = PGM_IDX_FLAGS;
                in_nxt  = {18'd0, cmd_data[5:0], 2'd0, payload[5:0]};
              end
            endcase
          end
        end else if (in_arg && timeout) begin
          state_nxt = S_IDLE;
          set_to    = 1'b1;
        end
      end
      S_ISSUE: begin
        if (!pgm_block) begin
          if (op == OP_CLEAR_ALL) begin
            state_nxt = S_ISSUE2;
            idx_nxt   = PGM_IDX_FLAGS;
            in_nxt    = 32'h0000_3F00;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      S_ISSUE2: if (!pgm_block) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      op          <= '0;
      bad_slot    <= 1'b0;
      pgm_idx     <= '0;
      pgm_in      <= '0;
      mask_shadow <= '0;
      err_frame   <= 1'b0;
      err_timeout <= 1'b0;
      err_cmd     <= 1'b0;
    end else begin
      state    <= state_nxt;
      op       <= op_nxt;
      bad_slot <= bad_nxt;
      pgm_idx  <= idx_nxt;
      pgm_in   <= in_nxt;
      if (pgm_we && pgm_idx == PGM_IDX_MASK) mask_shadow <= pgm_in[5:0];
      // A new error raised alongside CLR_ERR survives the clear.
      err_frame   <= set_frame || (err_frame   && !clr_err);
      err_timeout <= set_to    || (err_timeout && !clr_err);
      err_cmd     <= set_cmd   || (err_cmd     && !clr_err);
    end
  end

endmodule

// File: tb/tb_cheat_pgm_loader.sv
// Directed bench for cheat_pgm_loader: frame decode, blocked-write retry, errors, timeout, reset.
module tb_cheat_pgm_loader;

  localparam int T = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_sof = 1'b0;
  logic [7:0]  cmd_data = 8'h00;
  logic        cmd_ready;
  logic        pgm_block = 1'b0;
  logic [2:0]  pgm_idx;
  logic        pgm_we;
  logic [31:0] pgm_in;
  logic [5:0]  mask_shadow;
  logic        busy, err_frame, err_timeout, err_cmd;

  int checks = 0;
  int failures = 0;
  int we_cnt = 0;
  int w0;

  cheat_pgm_loader #(.TIMEOUT_CYCLES(T), .TO_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_sof(cmd_sof), .cmd_data(cmd_data),
    .cmd_ready(cmd_ready), .pgm_block(pgm_block), .pgm_idx(pgm_idx), .pgm_we(pgm_we),
    .pgm_in(pgm_in), .mask_shadow(mask_shadow), .busy(busy), .err_frame(err_frame),
    .err_timeout(err_timeout), .err_cmd(err_cmd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (pgm_we) we_cnt <= we_cnt + 1;

  task automatic send_byte(input logic sof, input logic [7:0] d);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_sof = sof; cmd_data = d;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_sof = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", cmd_ready); end
    checks++; if (pgm_we !== 1'b0) begin failures++; $display("FAIL rst_we got=%b exp=0", pgm_we); end
    checks++; if (pgm_idx !== 3'd0 || pgm_in !== 32'd0) begin failures++; $display("FAIL rst_pgm got=%0d/%h exp=0/0", pgm_idx, pgm_in); end
    checks++; if (mask_shadow !== 6'd0 || busy !== 1'b0) begin failures++; $display("FAIL rst_mask_busy got=%h/%b exp=0/0", mask_shadow, busy); end
    checks++; if ({err_frame, err_timeout, err_cmd} !== 3'b000) begin failures++; $display("FAIL rst_err got=%b exp=000", {err_frame, err_timeout, err_cmd}); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_load_slot();
    w0 = we_cnt;
    send_byte(1, 8'h01); send_byte(0, 8'h03); send_byte(0, 8'hC0);
    send_byte(0, 8'h12); send_byte(0, 8'h34); send_byte(0, 8'hAB);
    @(negedge clk);
    checks++; if (pgm_we !== 1'b1 || cmd_ready !== 1'b0) begin failures++; $display("FAIL load_we got=%b/%b exp=1/0", pgm_we, cmd_ready); end
    checks++; if (pgm_idx !== 3'd3 || pgm_in !== 32'hC01234AB) begin failures++; $display("FAIL load_data got=%0d/%h exp=3/c01234ab", pgm_idx, pgm_in); end
    @(negedge clk);
    checks++; if (pgm_we !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL load_done got=%b%b%b exp=010", pgm_we, cmd_ready, busy); end
    checks++; if (we_cnt - w0 !== 1) begin failures++; $display("FAIL load_count got=%0d exp=1", we_cnt - w0); end
  endtask

  task automatic test_set_mask_blocked();
    w0 = we_cnt;
    send_byte(1, 8'h02);
    pgm_block = 1'b1;
    send_byte(0, 8'h2A);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (pgm_we !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL mask_held%0d got=%b/%b exp=0/1", i, pgm_we, busy); end
    end
    @(posedge clk); #1; pgm_block = 1'b0;
    @(negedge clk);
    checks++; if (pgm_we !== 1'b1 || pgm_idx !== 3'd6 || pgm_in !== 32'h2A) begin failures++; $display("FAIL mask_write got=%b/%0d/%h exp=1/6/2a", pgm_we, pgm_idx, pgm_in); end
    @(negedge clk);
    checks++; if (mask_shadow !== 6'h2A || we_cnt - w0 !== 1) begin failures++; $display("FAIL mask_shadow got=%h/%0d exp=2a/1", mask_shadow, we_cnt - w0); end
  endtask

  task automatic test_clear_all();
    w0 = we_cnt;
    send_byte(1, 8'h04);
    @(negedge clk);
    checks++; if (pgm_we !== 1'b1 || pgm_idx !== 3'd6 || pgm_in !== 32'h0) begin failures++; $display("FAIL clr_first got=%b/%0d/%h exp=1/6/0", pgm_we, pgm_idx, pgm_in); end
    @(posedge clk); #1; pgm_block = 1'b1;
    @(negedge clk);
    checks++; if (pgm_we !== 1'b0 || pgm_idx !== 3'd7 || busy !== 1'b1) begin failures++; $display("FAIL clr_held got=%b/%0d/%b exp=0/7/1", pgm_we, pgm_idx, busy); end
    @(posedge clk); #1; pgm_block = 1'b0;
    @(negedge clk);
    checks++; if (pgm_we !== 1'b1 || pgm_idx !== 3'd7 || pgm_in !== 32'h3F00) begin failures++; $display("FAIL clr_second got=%b/%0d/%h exp=1/7/3f00", pgm_we, pgm_idx, pgm_in); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || mask_shadow !== 6'h0 || we_cnt - w0 !== 2) begin failures++; $display("FAIL clr_done got=%b/%h/%0d exp=0/0/2", busy, mask_shadow, we_cnt - w0); end
  endtask

  task automatic test_bad_slot();
    w0 = we_cnt;
    send_byte(1, 8'h01); send_byte(0, 8'h07);
    @(negedge clk);
    checks++; if (err_cmd !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL bad_slot_flag got=%b/%b exp=1/1", err_cmd, busy); end
    send_byte(0, 8'h00); send_byte(0, 8'h00); send_byte(0, 8'h00); send_byte(0, 8'h00);
    @(negedge clk); @(negedge clk);
    checks++; if (busy !== 1'b0 || we_cnt - w0 !== 0) begin failures++; $display("FAIL bad_slot_nowrite got=%b/%0d exp=0/0", busy, we_cnt - w0); end
    send_byte(1, 8'h05);
    @(negedge clk);
    checks++; if (err_cmd !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL clr_err got=%b/%b exp=0/0", err_cmd, busy); end
  endtask

  task automatic test_timeout();
    w0 = we_cnt;
    send_byte(1, 8'h03); send_byte(0, 8'h05);
    repeat (T) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1 || err_timeout !== 1'b0) begin failures++; $display("FAIL to_early got=%b/%b exp=1/0", busy, err_timeout); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || err_timeout !== 1'b1 || we_cnt - w0 !== 0) begin failures++; $display("FAIL to_abort got=%b/%b/%0d exp=0/1/0", busy, err_timeout, we_cnt - w0); end
    send_byte(1, 8'h03); send_byte(0, 8'h05); send_byte(0, 8'h02);
    @(negedge clk);
    checks++; if (pgm_we !== 1'b1 || pgm_idx !== 3'd7 || pgm_in !== 32'h0205) begin failures++; $display("FAIL flags_write got=%b/%0d/%h exp=1/7/205", pgm_we, pgm_idx, pgm_in); end
  endtask

  task automatic test_sof_abort();
    send_byte(1, 8'h05);
    @(negedge clk);
    checks++; if ({err_frame, err_timeout, err_cmd} !== 3'b000) begin failures++; $display("FAIL abort_pre got=%b exp=000", {err_frame, err_timeout, err_cmd}); end
    w0 = we_cnt;
    send_byte(1, 8'h01); send_byte(0, 8'h01); send_byte(0, 8'h00);
    send_byte(1, 8'h02);
    @(negedge clk);
    checks++; if (err_frame !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL abort_flag got=%b/%b exp=1/1", err_frame, busy); end
    send_byte(0, 8'h3F);
    @(negedge clk);
    checks++; if (pgm_we !== 1'b1 || pgm_idx !== 3'd6 || pgm_in !== 32'h3F) begin failures++; $display("FAIL abort_mask got=%b/%0d/%h exp=1/6/3f", pgm_we, pgm_idx, pgm_in); end
    @(negedge clk);
    checks++; if (we_cnt - w0 !== 1 || mask_shadow !== 6'h3F) begin failures++; $display("FAIL abort_count got=%0d/%h exp=1/3f", we_cnt - w0, mask_shadow); end
  endtask

  task automatic test_errors();
    send_byte(1, 8'h05);
    send_byte(0, 8'h55);
    @(negedge clk);
    checks++; if (err_frame !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL stray_byte got=%b/%b exp=1/0", err_frame, busy); end
    send_byte(1, 8'h09);
    @(negedge clk);
    checks++; if (err_cmd !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL bad_op got=%b/%b exp=1/0", err_cmd, busy); end
    send_byte(1, 8'h05);
    @(negedge clk);
    checks++; if ({err_frame, err_timeout, err_cmd} !== 3'b000) begin failures++; $display("FAIL clr_all_err got=%b exp=000", {err_frame, err_timeout, err_cmd}); end
  endtask

  task automatic test_reset_mid_issue();
    pgm_block = 1'b1;
    send_byte(1, 8'h02); send_byte(0, 8'h15);
    @(negedge clk);
    checks++; if (busy !== 1'b1 || pgm_in !== 32'h15) begin failures++; $display("FAIL issue_pending got=%b/%h exp=1/15", busy, pgm_in); end
    rst_n = 1'b0; #1; pgm_block = 1'b0; #1;
    checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1 || pgm_we !== 1'b0) begin failures++; $display("FAIL rst_issue got=%b%b%b exp=010", busy, cmd_ready, pgm_we); end
    checks++; if (pgm_in !== 32'd0 || mask_shadow !== 6'd0) begin failures++; $display("FAIL rst_issue_data got=%h/%h exp=0/0", pgm_in, mask_shadow); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_load_slot();
    test_set_mask_blocked();
    test_clear_all();
    test_bad_slot();
    test_timeout();
    test_sof_abort();
    test_errors();
    test_reset_mid_issue();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
